// File: rtl/if_fetch_queue_if.sv
// Instruction SRAM request/response bundle between the fetch stage and the SRAM.
interface if_fetch_queue_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, wstrb, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, wstrb, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: PC generation, pipelined SRAM requests with an in-flight PC FIFO,
// and an instruction buffer toward ID. Branch redirects flush the buffer and drop stale returns.
module if_fetch_queue #(
   parameter logic [31:0] RESET_PC   = 32'h1C00_0000,
   parameter int unsigned IBUF_DEPTH = 4,
   parameter int unsigned MAX_OUTST  = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ds_allowin_i,
   input  logic [32:0]             br_bus_i,
   output logic                    fs_to_ds_valid_o,
   output logic [63:0]             fs_to_ds_bus_o,
   if_fetch_queue_if.master        sram_if
);

   localparam int unsigned OutstW = $clog2(MAX_OUTST + 1);
   localparam int unsigned PfW    = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int unsigned IbW    = $clog2(IBUF_DEPTH);
   localparam int unsigned CntW   = $clog2(IBUF_DEPTH + 1);

   logic [31:0]       fetch_pc_q, fetch_pc_d;
   logic [OutstW-1:0] outst_q, outst_d;
   logic [OutstW-1:0] discard_q, discard_d;
   logic [31:0]       pf_mem_q [MAX_OUTST];
   logic [PfW-1:0]    pf_wr_q, pf_wr_d;
   logic [PfW-1:0]    pf_rd_q, pf_rd_d;
   logic [63:0]       ib_mem_q [IBUF_DEPTH];
   logic [IbW-1:0]    ib_wr_q, ib_wr_d;
   logic [IbW-1:0]    ib_rd_q, ib_rd_d;
   logic [CntW-1:0]   ib_cnt_q, ib_cnt_d;

   logic        br_taken;
   logic [31:0] br_target;
   logic        req;
   logic        accept;
   logic        ret;
   logic        keep;
   logic        valid;
   logic        pop;

   function automatic logic [PfW-1:0] pf_next(input logic [PfW-1:0] p);
      if (32'(p) == MAX_OUTST - 1) begin
         return '0;
      end
      return p + PfW'(1);
   endfunction

   // Handshake decode; buffer slots are reserved at request time so returns never stall.
   always_comb begin
      br_taken  = br_bus_i[32];
      br_target = br_bus_i[31:0];
      req       = !reset && (32'(outst_q) < MAX_OUTST) &&
                  (32'(outst_q) + 32'(ib_cnt_q) < IBUF_DEPTH);
      accept    = req && sram_if.addr_ok;
      ret       = !reset && sram_if.data_ok;
      keep      = ret && (discard_q == '0) && !br_taken;
      valid     = !reset && (ib_cnt_q != '0) && !br_taken;
      pop       = valid && ds_allowin_i;
   end

   // Outputs toward SRAM and ID.
   always_comb begin
      sram_if.req      = req;
      sram_if.wr       = 1'b0;
      sram_if.size     = 2'b10;
      sram_if.wstrb    = 4'h0;
      sram_if.addr     = fetch_pc_q;
      sram_if.wdata    = 32'h0;
      fs_to_ds_valid_o = valid;
      fs_to_ds_bus_o   = ib_mem_q[ib_rd_q];
   end

   // Next-state for PC, outstanding/discard counters and both FIFO pointer sets.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      outst_d    = outst_q;
      discard_d  = discard_q;
      pf_wr_d    = pf_wr_q;
      pf_rd_d    = pf_rd_q;
      ib_wr_d    = ib_wr_q;
      ib_rd_d    = ib_rd_q;
      ib_cnt_d   = ib_cnt_q;

      if (accept) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
         pf_wr_d    = pf_next(pf_wr_q);
      end
      if (ret) begin
         pf_rd_d = pf_next(pf_rd_q);
      end

      unique case ({accept, ret})
         2'b10:   outst_d = outst_q + OutstW'(1);
         2'b01:   outst_d = outst_q - OutstW'(1);
         default: outst_d = outst_q;
      endcase

      if (ret && (discard_q != '0)) begin
         discard_d = discard_q - OutstW'(1);
      end

      if (br_taken) begin
         // Everything still in flight after this cycle carries a stale address.
         fetch_pc_d = br_target;
         discard_d  = outst_d;
         ib_rd_d    = ib_wr_q;
         ib_cnt_d   = '0;
      end else begin
         if (keep) begin
            ib_wr_d = ib_wr_q + IbW'(1);
         end
         if (pop) begin
            ib_rd_d = ib_rd_q + IbW'(1);
         end
         unique case ({keep, pop})
            2'b10:   ib_cnt_d = ib_cnt_q + CntW'(1);
            2'b01:   ib_cnt_d = ib_cnt_q - CntW'(1);
            default: ib_cnt_d = ib_cnt_q;
         endcase
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         outst_q    <= '0;
         discard_q  <= '0;
         pf_wr_q    <= '0;
         pf_rd_q    <= '0;
         ib_wr_q    <= '0;
         ib_rd_q    <= '0;
         ib_cnt_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         pf_wr_q    <= pf_wr_d;
         pf_rd_q    <= pf_rd_d;
         ib_wr_q    <= ib_wr_d;
         ib_rd_q    <= ib_rd_d;
         ib_cnt_q   <= ib_cnt_d;
      end
   end

   // FIFO storage; contents are qualified by the pointers, so no reset is needed.
   always_ff @(posedge clk) begin
      if (accept) begin
         pf_mem_q[pf_wr_q] <= fetch_pc_q;
      end
      if (keep) begin
         ib_mem_q[ib_wr_q] <= {sram_if.rdata, pf_mem_q[pf_rd_q]};
      end
   end

   // A response with nothing outstanding is an SRAM protocol violation.
   a_no_spurious_data_ok: assert property (
      @(posedge clk) disable iff (reset) sram_if.data_ok |-> (outst_q != '0)
   );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a queue-level reference model and an SRAM responder.
module tb_if_fetch_queue;

   localparam logic [31:0] RPC = 32'h1C00_0000;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned MAXO  = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ds_allowin = 1'b0;
   logic [32:0] br_bus = '0;
   logic        fs_to_ds_valid;
   logic [63:0] fs_to_ds_bus;

   if_fetch_queue_if sif ();

   if_fetch_queue #(
      .RESET_PC   (RPC),
      .IBUF_DEPTH (DEPTH),
      .MAX_OUTST  (MAXO)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .ds_allowin_i     (ds_allowin),
      .br_bus_i         (br_bus),
      .fs_to_ds_valid_o (fs_to_ds_valid),
      .fs_to_ds_bus_o   (fs_to_ds_bus),
      .sram_if          (sif)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Stimulus knobs for the next cycle.
   logic        rst_s = 1'b1;
   logic        allow_s = 1'b0;
   logic        br_s = 1'b0;
   logic [31:0] tgt_s = '0;
   logic        aok_s = 1'b0;
   int          lat_s = 0;

   // Reference model: fetch pointer, in-flight PCs, discard count, buffered {inst, pc}.
   logic [31:0] m_pc = RPC;
   logic [31:0] m_inflight[$];
   int          m_discard = 0;
   logic [63:0] m_ibuf[$];
   logic [31:0] delivered[$];

   // SRAM responder: accepted addresses and the cycle each may return.
   logic [31:0] sq_addr[$];
   int          sq_rdy[$];

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'hA5A5_5A5A ^ {a[7:0], a[31:8]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: drive inputs, compare DUT against model, then advance model and SRAM.
   task automatic step();
      logic        req_e, valid_e, acc, dok;
      logic [31:0] popped;
      @(negedge clk);
      dok         = !rst_s && (sq_addr.size() > 0) && (cyc >= sq_rdy[0]);
      reset       = rst_s;
      ds_allowin  = allow_s;
      br_bus      = {br_s, tgt_s};
      sif.addr_ok = aok_s;
      sif.data_ok = dok;
      sif.rdata   = dok ? inst_of(sq_addr[0]) : 32'h0;
      #1;
      if (rst_s) begin
         req_e   = 1'b0;
         valid_e = 1'b0;
      end else begin
         req_e   = (m_inflight.size() < MAXO) && (m_inflight.size() + m_ibuf.size() < DEPTH);
         valid_e = (m_ibuf.size() > 0) && !br_s;
      end
      chk("req", 64'(sif.req), 64'(req_e));
      chk("valid", 64'(fs_to_ds_valid), 64'(valid_e));
      if (req_e) chk("addr", 64'(sif.addr), 64'(m_pc));
      if (valid_e) chk("bus", fs_to_ds_bus, m_ibuf[0]);
      chk("const", 64'({sif.wr, sif.size, sif.wstrb, sif.wdata}), 64'({1'b0, 2'b10, 4'h0, 32'h0}));

      if (dok) begin
         void'(sq_addr.pop_front());
         void'(sq_rdy.pop_front());
      end
      if (!rst_s && sif.req && aok_s) begin
         sq_addr.push_back(sif.addr);
         sq_rdy.push_back(cyc + 1 + lat_s);
      end

      if (rst_s) begin
         sq_addr.delete();
         sq_rdy.delete();
         m_pc = RPC;
         m_inflight.delete();
         m_discard = 0;
         m_ibuf.delete();
      end else begin
         acc = req_e && aok_s;
         if (valid_e && allow_s) begin
            delivered.push_back(m_ibuf[0][31:0]);
            void'(m_ibuf.pop_front());
         end
         if (dok && m_inflight.size() > 0) begin
            popped = m_inflight.pop_front();
            if (m_discard > 0) m_discard--;
            else if (!br_s) m_ibuf.push_back({inst_of(popped), popped});
         end
         if (acc) begin
            m_inflight.push_back(m_pc);
            m_pc = m_pc + 32'd4;
         end
         if (br_s) begin
            m_pc = tgt_s;
            m_ibuf.delete();
            m_discard = m_inflight.size();
         end
      end
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic redirect(input logic [31:0] t);
      br_s  = 1'b1;
      tgt_s = t;
      step();
      br_s  = 1'b0;
   endtask

   // Bounded wait until the model has two requests in flight.
   task automatic wait_two_inflight(input string name);
      for (int k = 0; k < 20 && m_inflight.size() != 2; k++) step();
      chk(name, 64'(m_inflight.size()), 64'd2);
   endtask

   task automatic chk_first_after(input string name, input int mark, input logic [31:0] exp);
      if (delivered.size() > mark) chk(name, 64'(delivered[mark]), 64'(exp));
      else chk(name, 64'hFFFF_FFFF, 64'(exp));
   endtask

   // Delivered pcs from index 'from' must be consecutive words.
   task automatic chk_order(input string name, input int from);
      int bad = 0;
      for (int i = from + 1; i < delivered.size(); i++) begin
         if (delivered[i] != delivered[i-1] + 32'd4 && bad == 0) bad = i;
      end
      chk(name, 64'(bad), 64'd0);
   endtask

   initial begin
      int mark;

      // Reset, then streaming with addr_ok=1 and one-cycle response latency.
      run(2);
      rst_s = 1'b0; allow_s = 1'b1; aok_s = 1'b1; lat_s = 0;
      run(12);
      chk("stream_count", 64'(delivered.size()), 64'd10);
      for (int i = 0; i < 4; i++) begin
         chk("stream_pc", 64'(delivered[i]), 64'(RPC + 32'(4 * i)));
      end

      // ID stalls for 10 cycles: buffer fills, requests stop, order kept afterwards.
      allow_s = 1'b0;
      run(10);
      chk("stall_model_fill", 64'(m_ibuf.size()), 64'd4);
      @(posedge clk); #1;
      chk("stall_req", 64'(sif.req), 64'd0);
      chk("stall_valid", 64'(fs_to_ds_valid), 64'd1);
      allow_s = 1'b1;
      run(12);
      chk_order("stall_order", 0);

      // Redirect with two requests in flight: both returns dropped.
      lat_s = 3;
      wait_two_inflight("br_setup");
      aok_s = 1'b0;
      mark = delivered.size();
      redirect(32'h1C00_0100);
      aok_s = 1'b1;
      run(25);
      chk_first_after("br_first", mark, 32'h1C00_0100);
      chk_order("br_order", mark);

      // Redirect coincident with data_ok and an accepted request.
      lat_s = 0;
      run(6);
      mark = delivered.size();
      redirect(32'h1C00_0200);
      run(10);
      chk_first_after("coinc_first", mark, 32'h1C00_0200);

      // Back-to-back redirects: the later target wins.
      mark = delivered.size();
      redirect(32'h1C00_0300);
      redirect(32'h1C00_0400);
      run(10);
      chk_first_after("b2b_first", mark, 32'h1C00_0400);

      // Random handshake delays with no branches: program order must hold.
      mark = delivered.size();
      for (int i = 0; i < 400; i++) begin
         aok_s   = ($urandom_range(0, 2) != 0);
         allow_s = ($urandom_range(0, 3) != 0);
         lat_s   = $urandom_range(0, 5);
         step();
      end
      aok_s = 1'b0; allow_s = 1'b1;
      run(30);
      chk_order("rand_order", mark);
      chk("rand_progress", 64'(delivered.size() > mark + 50), 64'd1);

      // Reset with two requests in flight; fetch restarts at the reset PC.
      aok_s = 1'b1; lat_s = 4;
      wait_two_inflight("rst_setup");
      rst_s = 1'b1;
      run(2);
      @(posedge clk); #1;
      chk("rst_req", 64'(sif.req), 64'd0);
      chk("rst_valid", 64'(fs_to_ds_valid), 64'd0);
      chk("rst_addr", 64'(sif.addr), 64'(RPC));
      rst_s = 1'b0; lat_s = 0;
      mark = delivered.size();
      run(10);
      chk_first_after("rst_first", mark, RPC);
      chk_order("rst_order", mark);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
